dmem_mmio_bridge: RTL and testbench
===================================

Name: dmem_mmio_bridge

Overview:
- Sits between the processor data-memory port and the data RAM.
- Decodes address_dmem[11:0]. Addresses 0x000–0xEFF pass through to the RAM. Addresses 0xF00–0xFFF hit a small memory-mapped I/O block.
- The I/O block holds:
  - button state and sticky edge flags;
  - a prescaled free-running timer;
  - an 8-deep output event FIFO with a valid/ready stream toward the game display/sound logic.
- Read data returns with the same one-cycle latency as the RAM, so the processor sees uniform lw timing.

Parameters:
- PRESCALE, 50000, clock cycles per timer increment; must be ≥1.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of two, ≤8.
- NUM_BTN, 4, button inputs.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- wren  in  1  processor store enable
- address_dmem  in  32  processor data address; bits [31:12] ignored
- data  in  32  processor store data
- q_dmem  out  32  load data to processor, valid the cycle after address is presented
- ram_wEn  out  1  RAM write enable
- ram_addr  out  12  RAM address
- ram_dataIn  out  32  RAM write data
- ram_dataOut  in  32  RAM read data, one-cycle synchronous
- btn  in  NUM_BTN  raw asynchronous button levels
- evt_valid  out  1  FIFO head valid
- evt_data  out  32  FIFO head word
- evt_ready  in  1  consumer accepts head when high with evt_valid

Behaviour:
- Decode: io_sel = (address_dmem[11:8] == 4'hF).
  - ram_addr = address_dmem[11:0] always.
  - ram_dataIn = data always.
  - ram_wEn = wren & ~io_sel; combinational, zero latency.
- Read path:
  - On each posedge, register rd_io = io_sel and rd_io_data = MMIO mux value.
  - q_dmem = rd_io ? rd_io_data : ram_dataOut.
  - Reset: rd_io=0, rd_io_data=0.
- Register map (offset = address_dmem[7:0] with io_sel set):
  - 0x00 BTN_STATE, RO: bits[NUM_BTN-1:0] = 2-flop-synchronized btn; upper bits 0.
  - 0x01 BTN_EDGE, R/W1C: sticky rising-edge flags from the synchronized level (sync_q & ~prev).
    - A write clears the bits where data=1.
    - A new edge in the same cycle as its clear leaves the bit SET.
  - 0x02 TIMER, R/W: 32-bit counter.
    - Prescaler counts 0..PRESCALE-1; the timer increments when the prescaler wraps.
    - A write loads data and resets the prescaler to 0; write beats increment.
    - Wraps 0xFFFFFFFF→0.
  - 0x03 FIFO_STATUS, R/W1C:
    - bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] count.
    - Writing data[2]=1 clears overflow; a simultaneous overflow event wins.
  - 0x04 FIFO_PUSH, WO: a write enqueues data. Reads return 0.
  - All other offsets: read 0, writes ignored.
- Read values are pre-edge state; a read and write to the same register in one cycle returns the old value.
- FIFO:
  - Circular buffer with 3-bit read and write pointers and a 4-bit count.
  - evt_valid = (count≠0); evt_data = mem[rd_ptr]. Both derive from registers, not combinationally from evt_ready.
  - Pop when evt_valid & evt_ready.
  - Push when a FIFO_PUSH write occurs and (count<DEPTH or pop this cycle).
  - Push with pop: count unchanged, so pushing to a full FIFO with a simultaneous pop is accepted.
  - Push to a full FIFO without pop: data dropped, overflow set.
  - Pointers wrap modulo DEPTH.
- Reset values:
  - Outputs: q_dmem=0, evt_valid=0, evt_data=mem[0] (don't-care), ram_wEn follows wren/decode.
  - Internal state: timer, prescaler, edge flags, sync flops, pointers, count and overflow all 0.
  - Reset mid-operation discards FIFO contents immediately.

Decomposition:
- Shared package dmem_mmio_pkg holds:
  - IO_BASE=4'hF;
  - offsets OFF_BTN_STATE=0, OFF_BTN_EDGE=1, OFF_TIMER=2, OFF_FIFO_STATUS=3, OFF_FIFO_PUSH=4;
  - status bit positions.
- One sub-module, evt_fifo (sync FIFO with push/pop/full/empty/count/overflow_pulse), instantiated once.
- Timer, button logic and decode stay inline.

Test Plan:
- Passthrough: sw 0xDEADBEEF to 0x123, then lw 0x123 → ram_wEn pulses once with ram_addr=0x123; q_dmem=0xDEADBEEF one cycle after the read address.
- MMIO isolation: sw to 0xF04 → ram_wEn stays 0; FIFO_STATUS read → count=1, empty=0.
- Buttons:
  - Raise btn[2] → BTN_STATE bit2=1 after 2 clocks; BTN_EDGE=0x4.
  - Write 0x4 to BTN_EDGE → reads 0.
  - New edge coincident with the clear → stays 0x4.
- Timer with PRESCALE=4:
  - Write 0xFFFFFFFE → after 4 clocks reads 0xFFFFFFFF, after 8 reads 0x0.
  - Write 10 coincident with a wrap → reads 10.
- FIFO fill, evt_ready=0:
  - Push 1..9 → status full=1, count=8, overflow=1; word 9 is lost.
  - Raise evt_ready → evt_data sequence 1..8, then evt_valid=0.
  - Push while full with evt_ready=1 → accepted, no overflow.
- Async reset asserted mid-stream with 5 entries queued → evt_valid=0, q_dmem=0 and TIMER=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared decode constants and status layout for the data-memory MMIO bridge
package dmem_mmio_pkg;

  // Upper address nibble that selects the I/O block instead of RAM
  localparam logic [3:0] IO_BASE = 4'hF;

  // Register offsets within the I/O page (address_dmem[7:0])
  localparam logic [7:0] OFF_BTN_STATE   = 8'h00;
  localparam logic [7:0] OFF_BTN_EDGE    = 8'h01;
  localparam logic [7:0] OFF_TIMER       = 8'h02;
  localparam logic [7:0] OFF_FIFO_STATUS = 8'h03;
  localparam logic [7:0] OFF_FIFO_PUSH   = 8'h04;

  // FIFO_STATUS bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef struct packed {
    logic       empty;
    logic       full;
    logic       overflow;
    logic [3:0] count;
  } fifo_status_t;

  // Pack FIFO status fields into the 32-bit register image
  function automatic logic [31:0] pack_status(input fifo_status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY] = s.empty;
    w[ST_FULL]  = s.full;
    w[ST_OVF]   = s.overflow;
    w[ST_CNT_LSB +: 4] = s.count;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_bridge_evt_fifo.sv
// rtl/dmem_mmio_bridge_evt_fifo.sv - circular event FIFO with push/pop, count and overflow pulse
module evt_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [31:0] push_data,
  input  logic        pop_ready,
  output logic        head_valid,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count,
  output logic        overflow_pulse
);

  // Pointers are always 3 bits; masking keeps them inside a smaller power-of-two depth
  localparam logic [2:0] PTR_MASK = 3'(DEPTH - 1);
  localparam logic [3:0] CNT_MAX  = 4'(DEPTH);

  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] mem_q [8];
  logic [31:0] mem_d [8];
  logic        pop;
  logic        accept;

  assign head_valid = (count_q != 4'd0);
  assign head_data  = mem_q[rd_ptr_q];
  assign full       = (count_q == CNT_MAX);
  assign empty      = (count_q == 4'd0);
  assign count      = count_q;

  // Pop/push arbitration; a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    pop            = head_valid & pop_ready;
    accept         = push_valid & ((count_q < CNT_MAX) | pop);
    overflow_pulse = push_valid & ~accept;
    count_d        = count_q + {3'b000, accept} - {3'b000, pop};
    wr_ptr_d       = accept ? ((wr_ptr_q + 3'd1) & PTR_MASK) : wr_ptr_q;
    rd_ptr_d       = pop    ? ((rd_ptr_q + 3'd1) & PTR_MASK) : rd_ptr_q;
    mem_d          = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  // Control state; reset empties the FIFO at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once count is cleared, so no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - data-memory port splitter between RAM and a small MMIO block
module dmem_mmio_bridge
  import dmem_mmio_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_BTN    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wren,
  input  logic [31:0]        address_dmem,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  output logic               ram_wEn,
  output logic [11:0]        ram_addr,
  output logic [31:0]        ram_dataIn,
  input  logic [31:0]        ram_dataOut,
  input  logic [NUM_BTN-1:0] btn,
  output logic               evt_valid,
  output logic [31:0]        evt_data,
  input  logic               evt_ready
);

  logic               io_sel;
  logic [7:0]         off;
  logic               io_wr;
  logic               unused_addr_hi;

  logic               rd_io_q, rd_io_d;
  logic [31:0]        rd_io_data_q, rd_io_data_d;

  logic [NUM_BTN-1:0] btn_meta_q, btn_meta_d;
  logic [NUM_BTN-1:0] btn_sync_q, btn_sync_d;
  logic [NUM_BTN-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_BTN-1:0] btn_edge_q, btn_edge_d;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] edge_clr;

  logic [31:0]        presc_q, presc_d;
  logic [31:0]        timer_q, timer_d;
  logic               presc_wrap;

  logic               ovf_q, ovf_d;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [3:0]         fifo_count;
  logic               fifo_ovf_pulse;
  fifo_status_t       status;

  assign io_sel         = (address_dmem[11:8] == IO_BASE);
  assign off            = address_dmem[7:0];
  assign io_wr          = wren & io_sel;
  assign unused_addr_hi = ^address_dmem[31:12];

  assign ram_addr   = address_dmem[11:0];
  assign ram_dataIn = data;
  assign ram_wEn    = wren & ~io_sel;

  assign q_dmem = rd_io_q ? rd_io_data_q : ram_dataOut;

  // Button synchronizer, rising-edge detect and write-1-to-clear sticky flags
  always_comb begin
    btn_meta_d = btn;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    btn_rise   = btn_sync_q & ~btn_prev_q;
    edge_clr   = (io_wr && off == OFF_BTN_EDGE) ? data[NUM_BTN-1:0] : '0;
    // A new edge in the clearing cycle wins so no press is lost
    btn_edge_d = (btn_edge_q & ~edge_clr) | btn_rise;
  end

  // Prescaled timer; a store reloads the count and restarts the prescaler
  always_comb begin
    presc_wrap = (presc_q == 32'(PRESCALE - 1));
    presc_d    = presc_wrap ? 32'd0 : presc_q + 32'd1;
    timer_d    = timer_q + {31'd0, presc_wrap};
    if (io_wr && off == OFF_TIMER) begin
      timer_d = data;
      presc_d = 32'd0;
    end
  end

  // FIFO push strobe and sticky overflow; a fresh overflow beats a clear
  always_comb begin
    fifo_push = io_wr && (off == OFF_FIFO_PUSH);
    ovf_d     = ovf_q;
    if (io_wr && off == OFF_FIFO_STATUS && data[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (fifo_ovf_pulse) begin
      ovf_d = 1'b1;
    end
  end

  // MMIO read mux sampled every cycle so loads see pre-edge register values
  always_comb begin
    status.empty    = fifo_empty;
    status.full     = fifo_full;
    status.overflow = ovf_q;
    status.count    = fifo_count;
    rd_io_d         = io_sel;
    case (off)
      OFF_BTN_STATE:   rd_io_data_d = 32'(btn_sync_q);
      OFF_BTN_EDGE:    rd_io_data_d = 32'(btn_edge_q);
      OFF_TIMER:       rd_io_data_d = timer_q;
      OFF_FIFO_STATUS: rd_io_data_d = pack_status(status);
      default:         rd_io_data_d = 32'd0;
    endcase
  end

  // All bridge state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_io_q      <= 1'b0;
      rd_io_data_q <= 32'd0;
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      btn_prev_q   <= '0;
      btn_edge_q   <= '0;
      presc_q      <= 32'd0;
      timer_q      <= 32'd0;
      ovf_q        <= 1'b0;
    end else begin
      rd_io_q      <= rd_io_d;
      rd_io_data_q <= rd_io_data_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      btn_prev_q   <= btn_prev_d;
      btn_edge_q   <= btn_edge_d;
      presc_q      <= presc_d;
      timer_q      <= timer_d;
      ovf_q        <= ovf_d;
    end
  end

  evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_evt_fifo (
    .clock          (clock),
    .reset          (reset),
    .push_valid     (fifo_push),
    .push_data      (data),
    .pop_ready      (evt_ready),
    .head_valid     (evt_valid),
    .head_data      (evt_data),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .count          (fifo_count),
    .overflow_pulse (fifo_ovf_pulse)
  );

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb/tb_dmem_mmio_bridge.sv - self-checking bench for dmem_mmio_bridge
module tb_dmem_mmio_bridge;

  localparam int PRESCALE = 4;
  localparam int DEPTH    = 8;
  localparam int NB       = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wren = 1'b0;
  logic [31:0]   address_dmem = 32'd0;
  logic [31:0]   data = 32'd0;
  logic [31:0]   q_dmem;
  logic          ram_wEn;
  logic [11:0]   ram_addr;
  logic [31:0]   ram_dataIn;
  logic [31:0]   ram_dataOut;
  logic [NB-1:0] btn = '0;
  logic          evt_valid;
  logic [31:0]   evt_data;
  logic          evt_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;

  logic [31:0] ram_mem [4096];

  always #5 clock = ~clock;

  dmem_mmio_bridge #(
    .PRESCALE  (PRESCALE),
    .FIFO_DEPTH(DEPTH),
    .NUM_BTN   (NB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_dmem      (q_dmem),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .btn         (btn),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_ready   (evt_ready)
  );

  // Synchronous RAM with one-cycle read latency
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_dataOut <= 32'd0;
    end else begin
      if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= ram_mem[ram_addr];
    end
  end

  always @(posedge clock) begin
    if (ram_wEn) wen_cnt <= wen_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    wren = 1'b0;
    tick();
    v = q_dmem;
  endtask

  function automatic logic [31:0] status_word(int cnt, bit ovf);
    return (32'(cnt) << 4) | (32'(ovf) << 2) | (32'(cnt == DEPTH) << 1) | 32'(cnt == 0);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (q_dmem !== 32'd0) begin
      $display("FAIL reset_q_dmem: got %h expected %h", q_dmem, 32'd0); n_fail++;
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); n_fail++;
    end
    reset = 1'b0;
    tick();
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(0, 0)) begin
      $display("FAIL reset_status: got %h expected %h", v, status_word(0, 0)); n_fail++;
    end
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_btn_edge: got %h expected 0", v); n_fail++;
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] v;
    int base;
    logic [31:0] exp_mem [int];
    logic [11:0] addrs [8];
    base = wen_cnt;
    address_dmem = 32'h123;
    data = 32'hDEADBEEF;
    wren = 1'b1;
    #1;
    n_checks++;
    if (ram_wEn !== 1'b1 || ram_addr !== 12'h123 || ram_dataIn !== 32'hDEADBEEF) begin
      $display("FAIL pass_wen: got wen=%b addr=%h din=%h expected 1 123 deadbeef", ram_wEn, ram_addr, ram_dataIn); n_fail++;
    end
    tick();
    wren = 1'b0;
    do_read(32'h123, v);
    n_checks++;
    if (v !== 32'hDEADBEEF) begin
      $display("FAIL pass_read: got %h expected deadbeef", v); n_fail++;
    end
    n_checks++;
    if (wen_cnt - base !== 1) begin
      $display("FAIL pass_wen_count: got %0d expected 1", wen_cnt - base); n_fail++;
    end
    exp_mem[12'h123] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 12'($urandom_range(0, 12'hEFF));
      data = $urandom;
      exp_mem[addrs[i]] = data;
      do_write({20'($urandom), addrs[i]}, data);
    end
    for (int i = 0; i < 8; i++) begin
      do_read({20'($urandom), addrs[i]}, v);
      n_checks++;
      if (v !== exp_mem[addrs[i]]) begin
        $display("FAIL pass_rand[%0d] addr %h: got %h expected %h", i, addrs[i], v, exp_mem[addrs[i]]); n_fail++;
      end
    end
  endtask

  task automatic test_mmio_isolation();
    logic [31:0] v;
    int base;
    base = wen_cnt;
    address_dmem = 32'hF04;
    data = 32'h55;
    wren = 1'b1;
    #1;
    n_checks++;
    if (ram_wEn !== 1'b0) begin
      $display("FAIL iso_wen: got %b expected 0", ram_wEn); n_fail++;
    end
    tick();
    wren = 1'b0;
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(1, 0)) begin
      $display("FAIL iso_status: got %h expected %h", v, status_word(1, 0)); n_fail++;
    end
    n_checks++;
    if (wen_cnt - base !== 0) begin
      $display("FAIL iso_wen_count: got %0d expected 0", wen_cnt - base); n_fail++;
    end
    do_read(32'hF04, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL iso_push_read: got %h expected 0", v); n_fail++;
    end
    do_write(32'hF20, 32'hFFFF_FFFF);
    do_read(32'hF20, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL iso_unmapped: got %h expected 0", v); n_fail++;
    end
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== 32'h55) begin
      $display("FAIL iso_head: got v=%b d=%h expected 1 55", evt_valid, evt_data); n_fail++;
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      $display("FAIL iso_drained: got %b expected 0", evt_valid); n_fail++;
    end
  endtask

  task automatic test_buttons();
    logic [31:0] v;
    btn[2] = 1'b1;
    tick();
    tick();
    do_read(32'hF00, v);
    n_checks++;
    if (v !== 32'h4) begin
      $display("FAIL btn_state: got %h expected 4", v); n_fail++;
    end
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'h4) begin
      $display("FAIL btn_edge: got %h expected 4", v); n_fail++;
    end
    do_write(32'hF01, 32'h4);
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL btn_clear: got %h expected 0", v); n_fail++;
    end
    btn[2] = 1'b0;
    repeat (4) tick();
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL btn_fall: got %h expected 0", v); n_fail++;
    end
    btn[2] = 1'b1;
    tick();
    tick();
    do_write(32'hF01, 32'h4);
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'h4) begin
      $display("FAIL btn_clear_race: got %h expected 4", v); n_fail++;
    end
    do_write(32'hF01, 32'hF);
    do_read(32'hF01, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL btn_clear2: got %h expected 0", v); n_fail++;
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    logic [31:0] r;
    int n;
    do_write(32'hF02, 32'hFFFF_FFFE);
    repeat (4) tick();
    do_read(32'hF02, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin
      $display("FAIL timer_4: got %h expected ffffffff", v); n_fail++;
    end
    repeat (3) tick();
    do_read(32'hF02, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL timer_wrap: got %h expected 0", v); n_fail++;
    end
    do_write(32'hF02, 32'hFFFF_FFFE);
    repeat (3) tick();
    do_write(32'hF02, 32'd10);
    n_checks++;
    if (q_dmem !== 32'hFFFF_FFFE) begin
      $display("FAIL timer_old_on_write: got %h expected fffffffe", q_dmem); n_fail++;
    end
    do_read(32'hF02, v);
    n_checks++;
    if (v !== 32'd10) begin
      $display("FAIL timer_load_race: got %h expected a", v); n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      n = $urandom_range(0, 15);
      do_write(32'hF02, r);
      repeat (n) tick();
      do_read(32'hF02, v);
      n_checks++;
      if (v !== r + 32'(n / PRESCALE)) begin
        $display("FAIL timer_rand[%0d]: got %h expected %h", i, v, r + 32'(n / PRESCALE)); n_fail++;
      end
    end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] v;
    evt_ready = 1'b0;
    for (int i = 1; i <= 9; i++) do_write(32'hF04, 32'(i));
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(8, 1)) begin
      $display("FAIL fill_status: got %h expected %h", v, status_word(8, 1)); n_fail++;
    end
    evt_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data !== 32'(i)) begin
        $display("FAIL fill_drain[%0d]: got v=%b d=%h expected 1 %h", i, evt_valid, evt_data, 32'(i)); n_fail++;
      end
      tick();
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      $display("FAIL fill_empty: got %b expected 0", evt_valid); n_fail++;
    end
    evt_ready = 1'b0;
    do_write(32'hF03, 32'h4);
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(0, 0)) begin
      $display("FAIL fill_ovf_clear: got %h expected %h", v, status_word(0, 0)); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 10; i <= 17; i++) do_write(32'hF04, 32'(i));
    evt_ready = 1'b1;
    do_write(32'hF04, 32'd18);
    evt_ready = 1'b0;
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(8, 0)) begin
      $display("FAIL full_push_pop_status: got %h expected %h", v, status_word(8, 0)); n_fail++;
    end
    evt_ready = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data !== 32'(i)) begin
        $display("FAIL full_push_pop_drain[%0d]: got v=%b d=%h expected 1 %h", i, evt_valid, evt_data, 32'(i)); n_fail++;
      end
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_fifo_random();
    logic [31:0] q[$];
    logic [31:0] v;
    logic [31:0] d;
    bit ovf = 0;
    bit rdy;
    bit push;
    bit pop;
    for (int i = 0; i < 80; i++) begin
      rdy  = ($urandom_range(0, 1) == 1);
      push = ($urandom_range(0, 2) != 0);
      d    = $urandom;
      evt_ready = rdy;
      address_dmem = push ? 32'hF04 : 32'h010;
      data = d;
      wren = push;
      n_checks++;
      if (evt_valid !== (q.size() != 0) || (q.size() != 0 && evt_data !== q[0])) begin
        $display("FAIL fifo_rand[%0d]: got v=%b d=%h expected v=%b d=%h", i, evt_valid, evt_data, q.size() != 0, (q.size() != 0) ? q[0] : 32'd0); n_fail++;
      end
      pop = rdy && q.size() != 0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovf = 1;
      end
      tick();
      wren = 1'b0;
    end
    evt_ready = 1'b0;
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(q.size(), ovf)) begin
      $display("FAIL fifo_rand_status: got %h expected %h", v, status_word(q.size(), ovf)); n_fail++;
    end
    do_write(32'hF03, 32'h4);
    evt_ready = 1'b1;
    while (q.size() != 0) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data !== q[0]) begin
        $display("FAIL fifo_rand_drain: got v=%b d=%h expected 1 %h", evt_valid, evt_data, q[0]); n_fail++;
      end
      void'(q.pop_front());
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_write(32'hF02, 32'h1234);
    for (int i = 0; i < 5; i++) do_write(32'hF04, $urandom);
    do_read(32'hF02, v);
    n_checks++;
    if (v !== 32'h1235 || evt_valid !== 1'b1) begin
      $display("FAIL pre_reset: got timer=%h v=%b expected 1235 1", v, evt_valid); n_fail++;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || q_dmem !== 32'd0) begin
      $display("FAIL async_reset: got v=%b q=%h expected 0 0", evt_valid, q_dmem); n_fail++;
    end
    tick();
    tick();
    reset = 1'b0;
    do_read(32'hF02, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_timer: got %h expected 0", v); n_fail++;
    end
    do_read(32'hF03, v);
    n_checks++;
    if (v !== status_word(0, 0)) begin
      $display("FAIL reset_fifo: got %h expected %h", v, status_word(0, 0)); n_fail++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = 32'd0;
    test_reset();
    test_passthrough();
    test_mmio_isolation();
    test_buttons();
    test_timer();
    test_fifo_fill();
    test_back_to_back();
    test_fifo_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
